// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: writeback-side initiator for the register file write port.
// Merges the in-order pipeline writeback (fixed priority, never back-pressured)
// with a FIFO-buffered secondary source (mul/div, late loads). At most one
// register write is issued per cycle, r0 is never written, and a one-cycle
// pipeline bubble (stall_req) is requested when the secondary source has been
// starved for STARVE_MAX consecutive cycles.
// Optional feature macro: WB_FWD_EN adds a bypass that reports hits on the
// register currently being written, for the cycle in which the register
// file still returns the old value.
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          p_valid,
  input  logic [ADDR_W-1:0]             p_rw,
  input  logic [DATA_W-1:0]             p_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [ADDR_W-1:0]             s_rw,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          stall_req,
  output logic                          wena,
  output logic [ADDR_W-1:0]             rw,
  output logic [DATA_W-1:0]             RegWriDate,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          proto_err
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]             fwd_ra,
  input  logic [ADDR_W-1:0]             fwd_rb,
  output logic                          fwd_a_hit,
  output logic                          fwd_b_hit,
  output logic [DATA_W-1:0]             fwd_a_data,
  output logic [DATA_W-1:0]             fwd_b_data
`endif
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0]    FULL_COUNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  logic [ADDR_W-1:0]   fifo_rw_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic [STARVE_W-1:0] starve_cnt;

  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                win_valid;
  logic [ADDR_W-1:0]   win_rw;
  logic [DATA_W-1:0]   win_data;
  logic                wena_next;

  assign fifo_empty = (count_q == '0);
  assign s_ready    = (count_q != FULL_COUNT);
  assign fifo_count = count_q;
  assign push       = s_valid && s_ready;
  assign stall_req  = (starve_cnt == STARVE_LIMIT);

  // Pick this cycle's winner: pipeline first, then the FIFO head, else idle.
  always_comb begin
    win_valid = 1'b0;
    win_rw    = '0;
    win_data  = '0;
    pop       = 1'b0;
    if (p_valid) begin
      win_valid = 1'b1;
      win_rw    = p_rw;
      win_data  = p_data;
    end else if (!fifo_empty) begin
      win_valid = 1'b1;
      win_rw    = fifo_rw_mem[rd_ptr];
      win_data  = fifo_data_mem[rd_ptr];
      pop       = 1'b1;
    end
    wena_next = win_valid && (win_rw != '0);
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_rw_mem[wr_ptr]   <= s_rw;
      fifo_data_mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Count consecutive cycles the pipeline blocks a waiting FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (p_valid && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Register the write port; index and data hold when no write happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      wena       <= 1'b0;
      rw         <= '0;
      RegWriDate <= '0;
    end else begin
      wena <= wena_next;
      if (wena_next) begin
        rw         <= win_rw;
        RegWriDate <= win_data;
      end
    end
  end

  // Sticky flag for a pipeline write that ignored a bubble request.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (p_valid && stall_req) begin
      proto_err <= 1'b1;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_a_hit  = wena && (rw == fwd_ra) && (fwd_ra != '0);
  assign fwd_b_hit  = wena && (rw == fwd_rb) && (fwd_rb != '0);
  assign fwd_a_data = fwd_a_hit ? RegWriDate : '0;
  assign fwd_b_data = fwd_b_hit ? RegWriDate : '0;
`endif

endmodule
